sram_port_arbiter: RTL and testbench

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

---
 rtl/knn_mem_pkg.sv | 21 ++
 rtl/sram_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/knn_mem_pkg.sv
// Shared types for the KNN memory-side blocks: arbiter FSM states and
// read-data ownership tags.
package knn_mem_pkg;

    typedef enum logic [1:0] {
        ENGINE,
        DRAIN,
        DEBUG
    } arb_state_t;

    typedef enum logic {
        OWN_ENG,
        OWN_WBS
    } owner_t;

    // Steady-state mode selected by the debug control bit.
    function automatic arb_state_t mode_target(input logic dbg_mode);
        return dbg_mode ? DEBUG : ENGINE;
    endfunction

endpackage

// File: rtl/sram_port_arbiter.sv
// Single-port SRAM arbiter between the KNN engine and the Wishbone slave.
// ENGINE mode gives the engine priority, DEBUG mode hands the port to
// Wishbone only; a one-cycle DRAIN separates the modes when a read is
// returning. Optional Wishbone starvation guard: ARB_STARVE_GUARD_EN.
module sram_port_arbiter
    import knn_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 9,
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned STARVE_LIMIT = 15
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  dbg_mode_i,
    input  logic                  eng_req_i,
    input  logic                  eng_we_i,
    input  logic [ADDR_WIDTH-1:0] eng_addr_i,
    input  logic [DATA_WIDTH-1:0] eng_wdata_i,
    output logic                  eng_gnt_o,
    output logic                  eng_rvalid_o,
    output logic [DATA_WIDTH-1:0] eng_rdata_o,
    input  logic                  wbs_req_i,
    input  logic                  wbs_we_i,
    input  logic [ADDR_WIDTH-1:0] wbs_addr_i,
    input  logic [DATA_WIDTH-1:0] wbs_wdata_i,
    output logic                  wbs_gnt_o,
    output logic                  wbs_rvalid_o,
    output logic [DATA_WIDTH-1:0] wbs_rdata_o,
    output logic                  mem_csb0_o,
    output logic                  mem_web0_o,
    output logic [ADDR_WIDTH-1:0] mem_addr0_o,
    output logic [DATA_WIDTH-1:0] mem_wdata0_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata0_i,
    output logic                  dbg_active_o
);

    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("STARVE_LIMIT must be at least 1");
    end

    arb_state_t state_q, state_d;
    logic       rd_pending_q, rd_pending_d;
    owner_t     rd_owner_q, rd_owner_d;

    logic mode_change;
    logic force_wbs;
    logic eng_gnt;
    logic wbs_gnt;

`ifdef ARB_STARVE_GUARD_EN
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_q, starve_d;

    // Starvation counter: counts denied Wishbone cycles while the engine owns the port.
    always_comb begin
        starve_d = starve_q;
        if (state_q == ENGINE) begin
            if (wbs_gnt) begin
                starve_d = '0;
            end else if (wbs_req_i && (starve_q != CNT_MAX)) begin
                starve_d = starve_q + 1'b1;
            end
        end
        force_wbs = (starve_q == CNT_MAX);
    end

    // Starvation counter register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    // Strict engine priority: Wishbone is never forced through.
    always_comb begin
        force_wbs = 1'b0;
    end
`endif

    // Grant decode: combinational from requests and state, suppressed on a mode change.
    always_comb begin
        mode_change = (state_q != DRAIN) && (dbg_mode_i != (state_q == DEBUG));
        eng_gnt     = 1'b0;
        wbs_gnt     = 1'b0;
        if (!wb_rst_i && !mode_change) begin
            case (state_q)
                ENGINE: begin
                    if (wbs_req_i && (!eng_req_i || force_wbs)) begin
                        wbs_gnt = 1'b1;
                    end else begin
                        eng_gnt = eng_req_i;
                    end
                end
                DEBUG:   wbs_gnt = wbs_req_i;
                default: ;
            endcase
        end
    end

    // SRAM port mux: the granted requester drives the macro, idle otherwise.
    always_comb begin
        mem_csb0_o   = 1'b1;
        mem_web0_o   = 1'b1;
        mem_addr0_o  = '0;
        mem_wdata0_o = '0;
        if (eng_gnt) begin
            mem_csb0_o   = 1'b0;
            mem_web0_o   = ~eng_we_i;
            mem_addr0_o  = eng_addr_i;
            mem_wdata0_o = eng_wdata_i;
        end else if (wbs_gnt) begin
            mem_csb0_o   = 1'b0;
            mem_web0_o   = ~wbs_we_i;
            mem_addr0_o  = wbs_addr_i;
            mem_wdata0_o = wbs_wdata_i;
        end
    end

    // Read tracker and FSM next state.
    always_comb begin
        rd_pending_d = (eng_gnt && !eng_we_i) || (wbs_gnt && !wbs_we_i);
        rd_owner_d   = rd_owner_q;
        if (wbs_gnt) begin
            rd_owner_d = OWN_WBS;
        end else if (eng_gnt) begin
            rd_owner_d = OWN_ENG;
        end

        state_d = state_q;
        case (state_q)
            ENGINE, DEBUG: begin
                if (mode_change) begin
                    state_d = rd_pending_q ? DRAIN : mode_target(dbg_mode_i);
                end
            end
            DRAIN:   state_d = mode_target(dbg_mode_i);
            default: state_d = ENGINE;
        endcase
    end

    // State, pending-read flag and owner registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q      <= ENGINE;
            rd_pending_q <= 1'b0;
            rd_owner_q   <= OWN_ENG;
        end else begin
            state_q      <= state_d;
            rd_pending_q <= rd_pending_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

    // Read return steering and status outputs.
    always_comb begin
        eng_gnt_o    = eng_gnt;
        wbs_gnt_o    = wbs_gnt;
        eng_rvalid_o = rd_pending_q && (rd_owner_q == OWN_ENG);
        wbs_rvalid_o = rd_pending_q && (rd_owner_q == OWN_WBS);
        eng_rdata_o  = eng_rvalid_o ? mem_rdata0_i : '0;
        wbs_rdata_o  = wbs_rvalid_o ? mem_rdata0_i : '0;
        dbg_active_o = (state_q == DEBUG);
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: behavioural SRAM, reference model of the
// arbitration rules, per-cycle compare plus hand-computed directed checks.
module tb_sram_port_arbiter;

    localparam int AW    = 9;
    localparam int DW    = 64;
    localparam int LIMIT = 15;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          dbg_mode;
    logic          eng_req, eng_we, wbs_req, wbs_we;
    logic [AW-1:0] eng_addr, wbs_addr;
    logic [DW-1:0] eng_wdata, wbs_wdata;
    logic          eng_gnt, eng_rvalid, wbs_gnt, wbs_rvalid;
    logic [DW-1:0] eng_rdata, wbs_rdata;
    logic          csb, web, dbg_active;
    logic [AW-1:0] maddr;
    logic [DW-1:0] mwdata, mrdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .dbg_mode_i  (dbg_mode),
        .eng_req_i   (eng_req),
        .eng_we_i    (eng_we),
        .eng_addr_i  (eng_addr),
        .eng_wdata_i (eng_wdata),
        .eng_gnt_o   (eng_gnt),
        .eng_rvalid_o(eng_rvalid),
        .eng_rdata_o (eng_rdata),
        .wbs_req_i   (wbs_req),
        .wbs_we_i    (wbs_we),
        .wbs_addr_i  (wbs_addr),
        .wbs_wdata_i (wbs_wdata),
        .wbs_gnt_o   (wbs_gnt),
        .wbs_rvalid_o(wbs_rvalid),
        .wbs_rdata_o (wbs_rdata),
        .mem_csb0_o  (csb),
        .mem_web0_o  (web),
        .mem_addr0_o (maddr),
        .mem_wdata0_o(mwdata),
        .mem_rdata0_i(mrdata),
        .dbg_active_o(dbg_active)
    );

    // Behavioural SRAM: unwritten words hold a fixed address-derived pattern.
    logic [DW-1:0] sram    [0:511];
    bit            written [0:511];

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        if (written[a]) return sram[a];
        if (a == 9'h005) return 64'hDEAD_BEEF_0000_0001;
        return {23'd0, a, 32'hA5A5_0000 | {23'd0, a}};
    endfunction

    always @(posedge clk) begin
        if (!csb) begin
            if (!web) begin
                sram[maddr]    <= mwdata;
                written[maddr] <= 1'b1;
            end else begin
                mrdata <= mem_word(maddr);
            end
        end
    end

    // Reference model: mode 0 = engine-owned, 1 = drain, 2 = debug.
    int            m_state  = 0;
    bit            m_pend   = 0;
    bit            m_owner  = 0;
    logic [DW-1:0] m_pdata  = '0;
    int            m_starve = 0;
    bit            e_eng_gnt, e_wbs_gnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Advance to the sampling point and compare every output with the model.
    task automatic settle();
        bit            blocked;
        bit            e_csb, e_web, e_erv, e_wrv;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        @(negedge clk);
        e_eng_gnt = 0;
        e_wbs_gnt = 0;
        if (!rst) begin
            blocked = (m_state == 1) || (dbg_mode != (m_state == 2));
            if (!blocked) begin
                if (m_state == 2) e_wbs_gnt = wbs_req;
                else if (wbs_req && (!eng_req || (GUARD && m_starve == LIMIT))) e_wbs_gnt = 1;
                else e_eng_gnt = eng_req;
            end
        end
        e_csb = 1; e_web = 1; e_addr = '0; e_wdata = '0;
        if (e_eng_gnt) begin
            e_csb = 0; e_web = !eng_we; e_addr = eng_addr; e_wdata = eng_wdata;
        end
        if (e_wbs_gnt) begin
            e_csb = 0; e_web = !wbs_we; e_addr = wbs_addr; e_wdata = wbs_wdata;
        end
        e_erv = !rst && m_pend && !m_owner;
        e_wrv = !rst && m_pend && m_owner;
        chk("cyc_eng_gnt", eng_gnt, e_eng_gnt);
        chk("cyc_wbs_gnt", wbs_gnt, e_wbs_gnt);
        chk("cyc_csb", csb, e_csb);
        chk("cyc_web", web, e_web);
        chk("cyc_addr", maddr, e_addr);
        chk("cyc_wdata", mwdata, e_wdata);
        chk("cyc_eng_rvalid", eng_rvalid, e_erv);
        chk("cyc_wbs_rvalid", wbs_rvalid, e_wrv);
        chk("cyc_eng_rdata", eng_rdata, e_erv ? m_pdata : '0);
        chk("cyc_wbs_rdata", wbs_rdata, e_wrv ? m_pdata : '0);
        chk("cyc_dbg_active", dbg_active, !rst && m_state == 2);
    endtask

    // Apply the clock edge to the model, then move just past the edge.
    task automatic tick();
        int nxt;
        if (rst) begin
            m_state = 0; m_pend = 0; m_starve = 0;
        end else begin
            nxt = m_state;
            if (m_state == 1) nxt = dbg_mode ? 2 : 0;
            else if (dbg_mode != (m_state == 2)) nxt = m_pend ? 1 : (dbg_mode ? 2 : 0);
            if (GUARD && m_state == 0) begin
                if (e_wbs_gnt) m_starve = 0;
                else if (wbs_req && m_starve < LIMIT) m_starve++;
            end
            m_pend = (e_eng_gnt && !eng_we) || (e_wbs_gnt && !wbs_we);
            if (e_eng_gnt) begin m_owner = 0; m_pdata = mem_word(eng_addr); end
            if (e_wbs_gnt) begin m_owner = 1; m_pdata = mem_word(wbs_addr); end
            m_state = nxt;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wg_cnt, wg_first, wg_second;
        rst = 1; dbg_mode = 0;
        eng_req = 0; eng_we = 0; eng_addr = '0; eng_wdata = '0;
        wbs_req = 0; wbs_we = 0; wbs_addr = '0; wbs_wdata = '0;

        // Reset state
        settle();
        chk("rst_csb", csb, 1);
        chk("rst_dbg_active", dbg_active, 0);
        tick();
        rst = 0;

        // Engine read of 0x05, data one cycle later only
        eng_req = 1; eng_addr = 9'h005;
        settle();
        chk("rd5_gnt", eng_gnt, 1);
        chk("rd5_csb", csb, 0);
        chk("rd5_web", web, 1);
        tick();
        eng_req = 0;
        settle();
        chk("rd5_rvalid", eng_rvalid, 1);
        chk("rd5_rdata", eng_rdata, 64'hDEAD_BEEF_0000_0001);
        tick();
        settle();
        chk("rd5_rvalid_once", eng_rvalid, 0);
        tick();

        // Wishbone write, then Wishbone read losing once to an engine read
        wbs_req = 1; wbs_we = 1; wbs_addr = 9'h010; wbs_wdata = 64'h0123_4567_89AB_CDEF;
        settle(); tick();
        wbs_we = 0; eng_req = 1; eng_addr = 9'h011;
        settle();
        chk("prio_wbs_gnt", wbs_gnt, 0);
        chk("prio_eng_gnt", eng_gnt, 1);
        tick();
        eng_req = 0;
        settle();
        chk("prio_wbs_late_gnt", wbs_gnt, 1);
        tick();
        wbs_req = 0;
        settle();
        chk("wbs_rdata_lit", wbs_rdata, 64'h0123_4567_89AB_CDEF);
        tick();

        // Back-to-back engine accesses, alternating read and write
        for (int i = 0; i < 6; i++) begin
            eng_req = 1; eng_we = i[0]; eng_addr = 9'(9'h040 + i); eng_wdata = 64'(i * 77);
            settle(); tick();
        end
        eng_req = 0; eng_we = 0;
        settle(); tick();

        // Sustained conflict: Wishbone starves unless the guard is built in
        eng_req = 1; eng_addr = 9'h030; wbs_req = 1; wbs_addr = 9'h031;
        wg_cnt = 0; wg_first = 0; wg_second = 0;
        for (int c = 1; c <= 40; c++) begin
            settle();
            if (wbs_gnt) begin
                wg_cnt++;
                if (wg_first == 0) wg_first = c;
                else if (wg_second == 0) wg_second = c;
            end
            tick();
        end
        eng_req = 0; wbs_req = 0;
        chk("starve_gnt_count", 64'(wg_cnt), GUARD ? 64'd2 : 64'd0);
        chk("starve_first_cycle", 64'(wg_first), GUARD ? 64'd16 : 64'd0);
        chk("starve_second_cycle", 64'(wg_second), GUARD ? 64'd32 : 64'd0);
        settle(); tick();

        // Debug entry right after an engine read grant
        eng_req = 1; eng_addr = 9'h005;
        settle(); tick();
        eng_req = 0; dbg_mode = 1;
        wbs_req = 1; wbs_we = 1; wbs_addr = 9'h1FF; wbs_wdata = 64'h0000_0000_0000_FEED;
        settle();
        chk("dbg_in_rvalid", eng_rvalid, 1);
        chk("dbg_in_blocked", wbs_gnt, 0);
        tick();
        settle();
        chk("drain_no_gnt", wbs_gnt, 0);
        chk("drain_not_dbg", dbg_active, 0);
        tick();
        eng_req = 1; eng_addr = 9'h007;
        settle();
        chk("dbg_active", dbg_active, 1);
        chk("dbg_eng_gnt", eng_gnt, 0);
        chk("dbg_wr_csb", csb, 0);
        chk("dbg_wr_web", web, 0);
        tick();
        wbs_we = 0;
        settle(); tick();
        // Leave debug while a Wishbone read is returning
        wbs_req = 0; dbg_mode = 0;
        settle();
        chk("dbg_out_rdata", wbs_rdata, 64'h0000_0000_0000_FEED);
        tick();
        settle(); tick();
        settle();
        chk("back_eng_gnt", eng_gnt, 1);
        tick();
        eng_req = 0;

        // Debug exit without a pending read
        dbg_mode = 1;
        settle(); tick();
        settle(); tick();
        dbg_mode = 0; eng_req = 1; eng_addr = 9'h002;
        settle();
        chk("exit_blocked", eng_gnt, 0);
        tick();
        settle();
        chk("exit_dbg_active", dbg_active, 0);
        chk("exit_eng_gnt", eng_gnt, 1);
        tick();
        eng_req = 0;
        settle(); tick();

        // Reset pulse right after a Wishbone read grant
        wbs_req = 1; wbs_we = 0; wbs_addr = 9'h010;
        settle(); tick();
        rst = 1; eng_req = 1;
        settle();
        chk("rst_wbs_rvalid", wbs_rvalid, 0);
        chk("rst_gnt", {eng_gnt, wbs_gnt}, 0);
        chk("rst_mem_csb", csb, 1);
        chk("rst_mem_addr", maddr, 0);
        tick();
        rst = 0; eng_req = 0; wbs_req = 0;
        settle();
        chk("post_rst_rvalid", wbs_rvalid, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
